// File: rtl/tinyqv_instr_prefetch.sv
// tinyqv_instr_prefetch
//   Buffers halfwords from the instruction memory controller and presents an
//   aligned 32-bit instruction word and its PC to the decoder. It tracks the
//   PC, works out the length of compressed and uncompressed instructions, and
//   flushes and refetches on a taken branch.
//
//   Build option: TINYQV_COMPRESSED_EN
//     Defined   : RVC is supported and instr_len is 2 or 4.
//     Undefined : every instruction is 32-bit and pc is word aligned.
//
//   Ports
//     clk, rstn       clock; synchronous active-low reset
//     fetch_addr      byte address of the halfword being requested
//     fetch_req       buffer can accept a halfword this cycle
//     fetch_valid     fetch_data holds the halfword at fetch_addr
//     fetch_data      returned halfword
//     fetch_restart   1-cycle pulse: restart the fetch burst at fetch_addr
//     instr           instruction at pc ({16'h0, hw0} when compressed)
//     pc              address of instr
//     instr_len       byte length of instr (2 or 4)
//     instr_valid     instr / pc / instr_len are valid
//     instr_complete  core retires the presented instruction
//     branch          redirect request (has priority over everything)
//     branch_target   redirect address
module tinyqv_instr_prefetch #(
  parameter int                 ADDR_W     = 24,
  parameter int                 DEPTH      = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_req,
  input  logic              fetch_valid,
  input  logic [15:0]       fetch_data,
  output logic              fetch_restart,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        instr_len,
  output logic              instr_valid,
  input  logic              instr_complete,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_target
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Address alignment: halfword with RVC, word without.
`ifdef TINYQV_COMPRESSED_EN
  localparam logic [ADDR_W-1:0] ALIGN = {{(ADDR_W-1){1'b1}}, 1'b0};
`else
  localparam logic [ADDR_W-1:0] ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

  logic [15:0]       mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_next, push_n, pop_len;
  logic [ADDR_W-1:0] pc_q, fa_q;
  logic              restart_q;
  logic [15:0]       hw0, hw1;
  logic              is32, push, pop;

  assign hw0 = mem[rd_ptr];
  assign hw1 = mem[rd_ptr + PW'(1)];

`ifdef TINYQV_COMPRESSED_EN
  assign is32 = (hw0[1:0] == 2'b11);
`else
  assign is32 = 1'b1;
`endif

  assign fetch_req   = (count < CW'(DEPTH));
  assign instr_valid = ((count >= CW'(1)) && !is32) || (count >= CW'(2));
  assign instr       = is32 ? {hw1, hw0} : {16'h0, hw0};
  assign instr_len   = is32 ? 3'd4 : 3'd2;
  assign pc          = pc_q;
  assign fetch_addr  = fa_q;
  assign fetch_restart = restart_q;

  // Branch kills both sides of the transfer on its edge.
  assign push = fetch_req & fetch_valid & !branch;
  assign pop  = instr_complete & instr_valid & !branch;

  assign push_n     = push ? CW'(1) : CW'(0);
  assign pop_len    = !pop ? CW'(0) : (is32 ? CW'(2) : CW'(1));
  assign count_next = count + push_n - pop_len;

  // Buffer storage needs no reset: nothing reads an entry until the
  // write pointer has moved past it.
  always_ff @(posedge clk) begin
    if (rstn && push) mem[wr_ptr] <= fetch_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pc_q      <= RESET_ADDR & ALIGN;
      fa_q      <= RESET_ADDR & ALIGN;
      restart_q <= 1'b0;
    end else if (branch) begin
      // Flush: keep wr_ptr, drop everything between rd_ptr and wr_ptr.
      rd_ptr    <= wr_ptr;
      count     <= '0;
      pc_q      <= branch_target & ALIGN;
      fa_q      <= branch_target & ALIGN;
      restart_q <= 1'b1;
    end else begin
      restart_q <= 1'b0;
      count     <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        fa_q   <= fa_q + ADDR_W'(2);
      end
      if (pop) begin
        // With PW==1 a pop of 2 leaves rd_ptr unchanged, which is the
        // correct modulo-DEPTH result.
        rd_ptr <= rd_ptr + pop_len[PW-1:0];
        pc_q   <= pc_q + ADDR_W'(instr_len);
      end
    end
  end

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
module tb_tinyqv_instr_prefetch;

  localparam int          AW   = 24;
  localparam logic [23:0] BASE = 24'h000100;
`ifdef TINYQV_COMPRESSED_EN
  localparam logic [23:0] BR = 24'h002002;
`else
  localparam logic [23:0] BR = 24'h002000;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] fetch_addr;
  logic          fetch_req;
  logic          fetch_valid;
  logic [15:0]   fetch_data;
  logic          fetch_restart;
  logic [31:0]   instr;
  logic [AW-1:0] pc;
  logic [2:0]    instr_len;
  logic          instr_valid;
  logic          instr_complete;
  logic          branch;
  logic [AW-1:0] branch_target;

  tinyqv_instr_prefetch #(.ADDR_W(AW), .DEPTH(4), .RESET_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn),
    .fetch_addr(fetch_addr), .fetch_req(fetch_req),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_restart(fetch_restart),
    .instr(instr), .pc(pc), .instr_len(instr_len), .instr_valid(instr_valid),
    .instr_complete(instr_complete),
    .branch(branch), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  // inputs | expected outputs (cl: also check instr and instr_len)
  typedef struct {
    logic        fv;
    logic [15:0] fd;
    logic        ic;
    logic        br;
    logic [23:0] bt;
    logic        ev;
    logic        cl;
    logic [31:0] ei;
    logic [2:0]  elen;
    logic [23:0] epc;
    logic        erq;
    logic [23:0] efa;
    logic        ers;
  } vec_t;

  vec_t vecs[15];
  int   nvec = 0;
  int   nerr = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [15:0] fd, input logic ic,
                       input logic br, input logic [23:0] bt);
    fetch_valid = fv; fetch_data = fd; instr_complete = ic;
    branch = br; branch_target = bt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0293, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 3'd0, 24'h100, 1'b1, 24'h102, 1'b0};
    vecs[1]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 32'h00000293, 3'd4, 24'h100, 1'b1, 24'h104, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 3'd0, 24'h104, 1'b1, 24'h104, 1'b0};
    vecs[3]  = '{1'b1, 16'h0013, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 3'd0, 24'h104, 1'b1, 24'h106, 1'b0};
    vecs[4]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 32'h00000013, 3'd4, 24'h104, 1'b1, 24'h108, 1'b0};
    vecs[5]  = '{1'b1, 16'h00b3, 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 32'h00000013, 3'd4, 24'h104, 1'b1, 24'h10a, 1'b0};
    vecs[6]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 32'h00000013, 3'd4, 24'h104, 1'b0, 24'h10c, 1'b0};
    vecs[7]  = '{1'b1, 16'hdead, 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 32'h00000013, 3'd4, 24'h104, 1'b0, 24'h10c, 1'b0};
    vecs[8]  = '{1'b1, 16'hbeef, 1'b1, 1'b0, 24'h0, 1'b1, 1'b1, 32'h001000b3, 3'd4, 24'h108, 1'b1, 24'h10c, 1'b0};
    vecs[9]  = '{1'b1, 16'h0037, 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 32'h001000b3, 3'd4, 24'h108, 1'b1, 24'h10e, 1'b0};
    vecs[10] = '{1'b1, 16'h1111, 1'b1, 1'b1, 24'h2003, 1'b0, 1'b0, 32'h0, 3'd0, BR, 1'b1, BR, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 3'd0, BR, 1'b1, BR, 1'b0};
    vecs[12] = '{1'b1, 16'h0297, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 3'd0, BR, 1'b1, BR + 24'd2, 1'b0};
    vecs[13] = '{1'b1, 16'h0000, 1'b1, 1'b0, 24'h0, 1'b1, 1'b1, 32'h00000297, 3'd4, BR, 1'b1, BR + 24'd4, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 3'd0, BR + 24'd4, 1'b1, BR + 24'd4, 1'b0};

    // Reset with a transfer in flight: the data must be discarded.
    rstn = 1'b0;
    drive(1'b1, 16'hffff, 1'b1, 1'b0, 24'h0);
    step(); step();
    rstn = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 24'h0);
    chk("rst_pc", 32'(pc), 32'h100);
    chk("rst_fetch_addr", 32'(fetch_addr), 32'h100);
    chk("rst_fetch_req", 32'(fetch_req), 32'h1);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_fetch_restart", 32'(fetch_restart), 32'h0);
    step();
    chk("rst_idle_valid", 32'(instr_valid), 32'h0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].fv, vecs[i].fd, vecs[i].ic, vecs[i].br, vecs[i].bt);
      step();
      nvec++;
      if (instr_valid !== vecs[i].ev || pc !== vecs[i].epc ||
          fetch_req !== vecs[i].erq || fetch_addr !== vecs[i].efa ||
          fetch_restart !== vecs[i].ers ||
          (vecs[i].cl && (instr !== vecs[i].ei || instr_len !== vecs[i].elen))) begin
        nerr++;
        $display("FAIL vec%0d: got v=%b i=%h l=%0d pc=%h rq=%b fa=%h rs=%b expected v=%b i=%h l=%0d pc=%h rq=%b fa=%h rs=%b",
                 i, instr_valid, instr, instr_len, pc, fetch_req, fetch_addr, fetch_restart,
                 vecs[i].ev, vecs[i].ei, vecs[i].elen, vecs[i].epc, vecs[i].erq, vecs[i].efa, vecs[i].ers);
      end
    end

    // Address wrap at the top of the address space.
    drive(1'b0, 16'h0, 1'b0, 1'b1, 24'hfffffc);
    step();
    chk("wrap_br_fa", 32'(fetch_addr), 32'hfffffc);
    drive(1'b1, 16'h0003, 1'b0, 1'b0, 24'h0);
    step();
    chk("wrap_fa1", 32'(fetch_addr), 32'hfffffe);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 24'h0);
    step();
    chk("wrap_fa0", 32'(fetch_addr), 32'h000000);
    chk("wrap_instr", instr, 32'h00000003);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 24'h0);
    step();
    chk("wrap_pc", 32'(pc), 32'h000000);
    chk("wrap_empty", 32'(instr_valid), 32'h0);

`ifdef TINYQV_COMPRESSED_EN
    // Mixed compressed / uncompressed stream.
    drive(1'b0, 16'h0, 1'b0, 1'b1, 24'h3000);
    step();
    drive(1'b1, 16'h4501, 1'b0, 1'b0, 24'h0);
    step();
    chk("rvc_single_valid", 32'(instr_valid), 32'h1);
    drive(1'b1, 16'h0513, 1'b0, 1'b0, 24'h0);
    step();
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 24'h0);
    step();
    chk("rvc_instr0", instr, 32'h00004501);
    chk("rvc_len0", 32'(instr_len), 32'd2);
    chk("rvc_pc0", 32'(pc), 32'h3000);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 24'h0);
    step();
    chk("rvc_instr1", instr, 32'h00000513);
    chk("rvc_len1", 32'(instr_len), 32'd4);
    chk("rvc_pc1", 32'(pc), 32'h3002);
    chk("rvc_valid1", 32'(instr_valid), 32'h1);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 24'h0);
    chk("rvc_pc2", 32'(pc), 32'h3006);
    chk("rvc_valid2", 32'(instr_valid), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
